// File: rtl/ysyx_22040237_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   ysyx_22040237_INST_WIDTH / ysyx_22040237_REG_WIDTH : core-wide widths
//   IFU_RESET_PC                                       : first fetch address after reset
//   ifu_state_e                                        : fetch FSM encoding (BOOT/RUN/HALT)
package ysyx_22040237_if_stage_pkg;

    localparam int ysyx_22040237_INST_WIDTH = 32;
    localparam int ysyx_22040237_REG_WIDTH  = 64;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IFU_BOOT = 2'd0,
        IFU_RUN  = 2'd1,
        IFU_HALT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040237_if_fifo.sv
// Parameterised synchronous FIFO with a synchronous flush.
// Used both as the fetched-instruction buffer and as the queue of PCs
// belonging to requests still waiting for their memory response.
// Ports:
//   clk, rst (async, active-low)
//   flush            : empties the FIFO; same-cycle push/pop are ignored
//   push, push_data  : write one entry (accepted when not full, or when popping)
//   pop              : remove the head entry (ignored when empty)
//   head_data        : current head entry (storage is reset to zero)
//   count            : number of valid entries
module ysyx_22040237_if_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/ysyx_22040237_if_stage.sv
// Instruction-fetch stage.
// Owns the fetch PC, issues in-order requests to instruction memory on a
// valid/ready channel, buffers returned instructions and presents them to
// decode on a valid/ready handshake. A redirect (flush_i) empties the buffer,
// moves the fetch PC and arranges for responses of the old path to be dropped.
// Ports:
//   clk, rst (async, active-low)
//   flush_i, redirect_pc_i              : jump redirect from EXU
//   halt_i                              : stop fetching, sticky until reset
//   imem_req_valid_o/ready_i/addr_o     : fetch request channel
//   imem_rsp_valid_i/data_i             : in-order responses, never back-pressured
//   out_valid_o/ready_i/pc_o/inst_o     : instruction to decode
// Configuration:
//   YSYX_22040237_IFU_64B_BUS_EN : memory returns aligned 64-bit words and the
//   instruction half is chosen by PC[2]; otherwise the low INST_W bits are used.
module ysyx_22040237_if_stage
    import ysyx_22040237_if_stage_pkg::*;
#(
    parameter int                ADDR_W     = ysyx_22040237_REG_WIDTH,
    parameter int                INST_W     = ysyx_22040237_INST_WIDTH,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [63:0]       imem_rsp_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [INST_W-1:0] out_inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e               state_r;
    logic [ADDR_W-1:0]        fetch_pc_r;
    logic [CNT_W-1:0]         drop_r;
    logic [CNT_W-1:0]         inflight_s;
    logic [CNT_W-1:0]         buf_cnt_s;
    logic [CNT_W:0]           credit_used_s;
    logic                     req_fire_s;
    logic                     rsp_keep_s;
    logic                     pop_s;
    logic [ADDR_W-1:0]        rsp_pc_s;
    logic [INST_W-1:0]        rsp_inst_s;
    logic [ADDR_W+INST_W-1:0] buf_head_s;

    // Buffered plus in-flight entries may never exceed the buffer depth,
    // which is what guarantees a response always finds room.
    assign credit_used_s    = {1'b0, buf_cnt_s} + {1'b0, inflight_s};
    assign imem_req_valid_o = (state_r == IFU_RUN) && !flush_i &&
                              (credit_used_s < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = fetch_pc_r;
    assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;

    // Responses of a redirected path are swallowed while drop_r is non-zero.
    assign rsp_keep_s = imem_rsp_valid_i && (drop_r == {CNT_W{1'b0}}) && !flush_i;

`ifdef YSYX_22040237_IFU_64B_BUS_EN
    assign rsp_inst_s = rsp_pc_s[2] ? imem_rsp_data_i[63:32] : imem_rsp_data_i[31:0];
`else
    logic unused_rsp_hi_s;
    assign unused_rsp_hi_s = ^imem_rsp_data_i[63:INST_W];
    assign rsp_inst_s      = imem_rsp_data_i[INST_W-1:0];
`endif

    assign out_valid_o = (buf_cnt_s != {CNT_W{1'b0}}) && !flush_i;
    assign pop_s       = out_valid_o && out_ready_i;
    assign out_pc_o    = buf_head_s[ADDR_W+INST_W-1:INST_W];
    assign out_inst_o  = buf_head_s[INST_W-1:0];

    // PC of every accepted request; its occupancy is the in-flight count.
    // Never flushed: stale responses still arrive and must retire their entry.
    ysyx_22040237_if_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire_s),
        .push_data (fetch_pc_r),
        .pop       (imem_rsp_valid_i),
        .head_data (rsp_pc_s),
        .count     (inflight_s)
    );

    ysyx_22040237_if_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (rsp_keep_s),
        .push_data ({rsp_pc_s, rsp_inst_s}),
        .pop       (pop_s),
        .head_data (buf_head_s),
        .count     (buf_cnt_s)
    );

    // Fetch FSM: one idle BOOT cycle, then RUN until a sticky HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IFU_BOOT;
        end else begin
            case (state_r)
                IFU_BOOT: state_r <= IFU_RUN;
                IFU_RUN:  state_r <= halt_i ? IFU_HALT : IFU_RUN;
                IFU_HALT: state_r <= IFU_HALT;
                default:  state_r <= IFU_BOOT;
            endcase
        end
    end

    // Fetch PC: redirect wins over the sequential advance; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (flush_i) begin
            fetch_pc_r <= redirect_pc_i;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + ADDR_W'(4);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Drop counter: on redirect every older in-flight response must be discarded;
    // a response arriving in the redirect cycle is already discarded directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            drop_r <= inflight_s - CNT_W'(imem_rsp_valid_i);
        end else if (imem_rsp_valid_i && (drop_r != {CNT_W{1'b0}})) begin
            drop_r <= drop_r - CNT_W'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_if_stage.sv
// Directed, scoreboard-based bench for ysyx_22040237_if_stage.
// A behavioural memory answers requests after a programmable latency; the
// bench keeps its own fetch-PC model and path tags to know which responses
// must reach decode and in which order.
module tb_ysyx_22040237_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'd0;
    logic        halt_i = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [63:0] imem_rsp_data_i = 64'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] out_pc_o;
    logic [31:0] out_inst_o;

    always #5 clk = ~clk;

    ysyx_22040237_if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .halt_i           (halt_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_pc_o         (out_pc_o),
        .out_inst_o       (out_inst_o)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];
    logic [95:0] sb[$];
    logic [63:0] out_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          req_cnt = 0;
    int          out_cnt = 0;
    bit          halted = 1'b0;
    logic [63:0] exp_pc = 64'h8000_0000;
    logic [63:0] last_req_addr = 64'd0;
    logic [63:0] last_out_pc = 64'd0;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_0000, a[31:0] ^ 32'h0000_BEEF};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] a);
        logic [63:0] d;
        d = mem_data(a);
`ifdef YSYX_22040237_IFU_64B_BUS_EN
        return a[2] ? d[63:32] : d[31:0];
`else
        return d[31:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        mreq_t       r;
        logic [95:0] e;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 64'd0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(r.addr);
            if (!r.stale && !flush_i) sb.push_back({r.addr, exp_inst(r.addr)});
        end
        #1;
        if (halted) check("no_req_in_halt", imem_req_valid_o, 1'b0);
        if (flush_i) begin
            check("flush_no_req", imem_req_valid_o, 1'b0);
            check("flush_no_out", out_valid_o, 1'b0);
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
            check("req_addr", imem_req_addr_o, exp_pc);
            mq.push_back('{exp_pc, cyc + lat, 1'b0});
            exp_pc        = exp_pc + 64'd4;
            last_req_addr = imem_req_addr_o;
            req_cnt++;
        end
        if (out_valid_o && out_ready_i) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_out observed_pc=%0h expected=none", out_pc_o);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_pc", out_pc_o, e[95:32]);
                check("out_inst", out_inst_o, e[31:0]);
            end
            out_log.push_back(out_pc_o);
            last_out_pc = out_pc_o;
            out_cnt++;
        end
        if (flush_i) begin
            exp_pc = redirect_pc_i;
            sb.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_req(input int n, input string tag);
        int budget;
        budget = 80;
        while (req_cnt < n && budget > 0) begin cycle(); budget--; end
        check(tag, req_cnt >= n, 1'b1);
    endtask

    task automatic run_until_out(input int n, input string tag);
        int budget;
        budget = 80;
        while (out_cnt < n && budget > 0) begin cycle(); budget--; end
        check(tag, out_cnt >= n, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0; halt_i = 1'b0;
        imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 64'd0;
        mq.delete(); sb.delete(); out_log.delete();
        halted = 1'b0;
        exp_pc = 64'h8000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int found;
        int budget;
        // ---- reset values ----
        @(negedge clk); #1;
        check("rst_req_valid", imem_req_valid_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_req_addr", imem_req_addr_o, 64'h8000_0000);
        check("rst_out_pc", out_pc_o, 64'd0);
        check("rst_out_inst", out_inst_o, 32'd0);

        // ---- basic streaming, 1-cycle memory ----
        imem_req_ready_i = 1'b1; out_ready_i = 1'b1; lat = 1;
        do_reset();
        #1;
        check("boot_no_req", imem_req_valid_o, 1'b0);
        cycle();
        check("first_req_valid", imem_req_valid_o, 1'b1);
        check("first_req_addr", imem_req_addr_o, 64'h8000_0000);
        run_until_out(out_cnt + 3, "t1_out_timeout");
        check("t1_pc0", out_log[0], 64'h8000_0000);
        check("t1_pc1", out_log[1], 64'h8000_0004);
        check("t1_pc2", out_log[2], 64'h8000_0008);

        // ---- credit limit with decode stalled ----
        out_ready_i = 1'b0;
        do_reset();
        base = req_cnt;
        repeat (10) cycle();
        check("t2_credit_reqs", req_cnt - base, 2);
        check("t2_req_blocked", imem_req_valid_o, 1'b0);
        out_ready_i = 1'b1;
        run_until_req(base + 3, "t2_resume_timeout");
        check("t2_resume_addr", last_req_addr, 64'h8000_0008);
        run_until_out(out_cnt + 3, "t2_out_timeout");

        // ---- flush in BOOT, then flush with two requests in flight ----
        lat = 4;
        do_reset();
        flush_i = 1'b1; redirect_pc_i = 64'h8000_0040;
        cycle();
        flush_i = 1'b0;
        base = req_cnt;
        run_until_req(base + 2, "t3_fill_timeout");
        check("t3_boot_redirect", last_req_addr, 64'h8000_0044);
        check("t3_two_inflight", mq.size(), 2);
        flush_i = 1'b1; redirect_pc_i = 64'h8000_0100;
        cycle();
        flush_i = 1'b0;
        base = req_cnt;
        run_until_req(base + 1, "t3_newpath_timeout");
        check("t3_newpath_addr", last_req_addr, 64'h8000_0100);
        run_until_out(out_cnt + 1, "t3_out_timeout");
        check("t3_first_out_pc", last_out_pc, 64'h8000_0100);

        // ---- flush coinciding with a response and a pop ----
        lat = 1;
        found = 0; budget = 40;
        while (found == 0 && budget > 0) begin
            if (mq.size() > 0 && mq[0].due <= cyc && out_valid_o) found = 1;
            else cycle();
            budget--;
        end
        check("t4_setup", found, 1);
        flush_i = 1'b1; redirect_pc_i = 64'h8000_0200;
        cycle();
        flush_i = 1'b0;
        #1;
        check("t4_empty_after_flush", out_valid_o, 1'b0);
        run_until_out(out_cnt + 1, "t4_out_timeout");
        check("t4_first_out_pc", last_out_pc, 64'h8000_0200);

        // ---- fetch PC wraps modulo 2^64 ----
        flush_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        flush_i = 1'b0;
        base = req_cnt;
        run_until_req(base + 2, "t5_wrap_timeout");
        check("t5_wrap_addr", last_req_addr, 64'd0);

        // ---- halt with a request in flight ----
        lat = 2;
        budget = 20;
        while (mq.size() == 0 && budget > 0) begin cycle(); budget--; end
        check("t6_inflight_setup", mq.size() > 0, 1'b1);
        base = out_cnt;
        halt_i = 1'b1;
        cycle();
        halt_i = 1'b0;
        halted = 1'b1;
        repeat (10) cycle();
        check("t6_rsp_reached_out", out_cnt > base, 1'b1);
        check("t6_sb_drained", sb.size(), 0);
        check("t6_mem_drained", mq.size(), 0);
        flush_i = 1'b1; redirect_pc_i = 64'h8000_0300;
        cycle();
        flush_i = 1'b0;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_if_stage.md
Name: ysyx_22040237_if_stage

Overview:
Instruction-fetch stage that feeds the single-cycle core's decode path. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel, with fixed-latency-agnostic in-order responses. Returned instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake. Jump redirects from EXU flush the FIFO, and the block discards any responses still in flight from the old path.

Parameters:
ADDR_W, 64, fetch address and PC width.
INST_W, 32, instruction width.
FIFO_DEPTH, 2, instruction buffer entries; also the credit limit on (buffered + in-flight) requests; power of two, ≥2.
RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset (0 = in reset).
flush_i  in  1  redirect strobe from EXU (pc_jump_flag).
redirect_pc_i  in  ADDR_W  new fetch PC, valid with flush_i.
halt_i  in  1  stop fetching (ebreak/invalid inst); sticky until reset.
imem_req_valid_o  out  1  fetch request valid.
imem_req_ready_i  in  1  memory accepts request.
imem_req_addr_o  out  ADDR_W  fetch address.
imem_rsp_valid_i  in  1  response strobe; in order; never back-pressured.
imem_rsp_data_i  in  64  response data; low INST_W bits used unless the optional feature is on.
out_valid_o  out  1  instruction available to decode.
out_ready_i  in  1  decode consumes.
out_pc_o  out  ADDR_W  PC of the presented instruction.
out_inst_o  out  INST_W  presented instruction.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0; FSM=BOOT. Outputs: imem_req_valid_o=0, out_valid_o=0, imem_req_addr_o=RESET_PC, out_pc_o=0, out_inst_o=0.
- FSM: BOOT goes to RUN one cycle after reset release, with no request in BOOT. RUN goes to HALT when halt_i=1. HALT is sticky and exits only through reset.
- In HALT, no new requests are issued. Outstanding responses are still accepted, and the FIFO still drains.
- Request: imem_req_valid_o = (FSM==RUN) & !flush_i & (fifo_cnt + inflight < FIFO_DEPTH). imem_req_addr_o = fetch_pc. Both are stable while valid && !ready.
- On request handshake: fetch_pc += 4 and inflight++.
- Response: inflight-- on every imem_rsp_valid_i.
  - If drop>0, the response is discarded and drop-- in the same cycle.
  - Otherwise {pc, inst} is pushed to the FIFO. The response PC comes from a PC queue advanced in request order.
  - The FIFO cannot overflow, by the credit rule.
- Output: out_valid_o = !fifo_empty & !flush_i. Fetch-to-decode latency is a minimum of 1 cycle after the response (registered FIFO). Pop on out_valid_o & out_ready_i.
- Simultaneous push and pop keeps the count unchanged. Push to an empty FIFO is visible the next cycle.
- Flush (highest priority):
  - FIFO cleared, with any same-cycle push or pop ignored.
  - fetch_pc = redirect_pc_i.
  - drop = inflight − (imem_rsp_valid_i ? 1 : 0). The same-cycle response is discarded.
  - No request is issued in the flush cycle. The first new-path request goes out the next cycle.
- Flush while in HALT still updates fetch_pc and drop, but no request follows.
- Flush while in BOOT is applied, and RUN then starts from redirect_pc_i.
- fetch_pc wraps modulo 2^ADDR_W.
- Reset asserted mid-transfer drops everything; the memory side is reset together with this block.

Optional Feature:
Macro: YSYX_22040237_IFU_64B_BUS_EN.
- Defined: memory returns aligned 64-bit words. The instruction is rsp_data[63:32] when the response PC[2]=1, else rsp_data[31:0].
- Undefined: the instruction is always rsp_data[INST_W-1:0], and imem_rsp_data_i upper bits are ignored.

Decomposition:
- Shared package/defines header:
  - ysyx_22040237_INST_WIDTH and ysyx_22040237_REG_WIDTH (existing).
  - RESET_PC constant.
  - FSM state encoding BOOT=2'd0, RUN=2'd1, HALT=2'd2.
- One natural sub-module: ysyx_22040237_if_fifo, a parameterised sync FIFO with flush, used for both the instruction buffer and the in-flight PC queue.

Test Plan:
- Reset release, imem_req_ready_i=1, 1-cycle response, out_ready_i=1 → first request addr 0x8000_0000 in cycle 2 after release. Output PCs are 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, with matching insts.
- out_ready_i=0, memory always ready → exactly FIFO_DEPTH=2 requests issued, then imem_req_valid_o=0. Raising out_ready_i resumes with addr 0x8000_0008.
- Two requests in flight, flush_i with redirect_pc_i=0x8000_0100 → both old responses discarded, no out_valid_o for them. Next request addr 0x8000_0100, and the first output PC is 0x8000_0100.
- Flush coinciding with a response and with out_ready_i=1 → the response is dropped, drop=inflight−1, the FIFO is empty next cycle, and no pop is counted.
- halt_i pulse with one request in flight → its response still reaches out_o, no further requests, and the state stays HALT after halt_i deasserts.
- With YSYX_22040237_IFU_64B_BUS_EN, response 0x1111_1111_2222_2222 for PC 0x8000_0004 → out_inst_o=0x1111_1111. For PC 0x8000_0000 → 0x2222_2222.
